uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Single-channel UART transmitter that serialises one parallel word per handshake onto an idle-high line, LSB first, with a configurable data width and an optional parity bit. It sits beneath the motor command packetiser (`uart_comm`), which feeds one ASCII byte at a time. The line drives the motor controller's RX pin through a GPIO.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115 200): clock cycles per bit period. Must be ≥ 2. Benches use small values such as 3 or 4.
- `BITS_N`, default 8: data bits per frame, 5–9 legal.
- `PARITY_TYPE`, default 0: parity mode.
  - 0 = none.
  - 1 = odd.
  - 2 = even.
  - 3 is treated as none.
- `clk` input 1: the only clock; all logic is on the rising edge.
- `rst` input 1: one clock; reset is synchronous and active-low. It is sampled on the `clk` rising edge, and 0 resets.
- `data_tx` input BITS_N: word to send; sampled only at acceptance.
- `valid` input 1: request to send `data_tx`.
- `ready` output 1: high when idle and able to accept a word.
- `uart_out` output 1: serial line, idle high.
- `baud_trigger` output 1: one-cycle pulse on the last clock of every bit period of a frame.

## Operation
- The state machine has five states.
  - IDLE: `uart_out`=1 and `ready`=1.
  - START: `uart_out`=0.
  - DATA: `uart_out` = shift register bit 0.
  - PARITY: `uart_out` = parity bit.
  - STOP: `uart_out`=1.
- Acceptance is `valid && ready` at a rising edge while in IDLE. On acceptance:
  - `data_tx` is latched into the shift register;
  - the parity bit is computed from the latched word (even: XOR of bits; odd: inverted XOR);
  - the bit counter and baud counter clear;
  - the state goes to START.
- The baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. The last count ends the bit period.
- Transitions at the end of each bit period:
  - START → DATA.
  - DATA → DATA after shifting right by one and incrementing the bit counter, until BITS_N bits have been sent.
  - After the last data bit: DATA → PARITY if parity is enabled, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Frame length is (2 + BITS_N + P) × CLKS_PER_BIT cycles, where P = 1 if parity is enabled, else 0.
- `valid` and `data_tx` are ignored while not in IDLE. Changes to `data_tx` mid-frame do not alter the frame.
- `baud_trigger`:
  - `baud_trigger` = 1 exactly when the state is not IDLE and the baud counter = CLKS_PER_BIT-1.
  - `baud_trigger` is 0 in IDLE.
- All outputs are registered. There is no combinational path from `valid` to `ready` or `uart_out`.

## Timing
- Reset values: `uart_out`=1, `ready`=1, `baud_trigger`=0. State = IDLE, and all counters and the shift register are cleared.
- Reset asserted mid-frame aborts the frame. From the next edge `uart_out`=1 and `ready`=1, and no partial bits resume.
- Acceptance at edge E:
  - from the cycle after E, `ready`=0 and `uart_out`=0;
  - the start bit lasts exactly CLKS_PER_BIT cycles;
  - each following bit also lasts CLKS_PER_BIT cycles.
- `ready` returns to 1 in the cycle immediately after the last stop-bit cycle.
- If `valid` is high at that point, the next frame is accepted on that edge. The next start bit then begins directly, with no idle gap beyond that one cycle of `ready`=1.
- A single `valid` pulse coincident with `ready`=1 is sufficient; holding `valid` high sends repeated frames.
- `valid` asserted while `ready`=0 is not queued.

## Test plan
Unless stated otherwise: CLKS_PER_BIT=4, BITS_N=8, PARITY_TYPE=0.
- Reset check: hold `rst`=0 for 3 cycles, then release. Expected: `uart_out`=1, `ready`=1, `baud_trigger`=0, and the line stays at 1 with no `valid`.
- Single frame: send 0x55.
  - Line, 4 cycles per bit: 0, 1,0,1,0,1,0,1,0, 1.
  - `ready` is low for exactly 40 cycles.
  - `baud_trigger` pulses 10 times, each on the 4th cycle of its bit.
- Parity modes: send 0x07 with PARITY_TYPE=2, then with PARITY_TYPE=1.
  - PARITY_TYPE=2: parity bit = 1.
  - PARITY_TYPE=1: parity bit = 0.
  - Frame is 44 cycles.
  - With 0x00: even parity = 0, odd parity = 1.
- Busy-ignore: start 0xA3, then pulse `valid` with `data_tx`=0xFF mid-frame. Expected: the line carries only 0xA3, and `ready` stays 0 until the frame ends.
- Back-to-back: hold `valid`=1 with 0x7B then 0x22. Expected: the second start bit begins exactly one cycle after the first stop bit ends, and both bytes decode correctly.
- Reset mid-frame: assert `rst`=0 during data bit 3 of 0x0F. Expected: `uart_out`=1 and `ready`=1 from the next edge. A subsequent 0x3A is then sent intact.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: serialises one BITS_N-bit word per valid/ready handshake,
// LSB first, with optional odd/even parity, onto an idle-high line.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out,
    output logic              baud_trigger
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(BITS_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_N - 1);
    localparam bit PARITY_EN = (PARITY_TYPE == 1) || (PARITY_TYPE == 2);
    localparam bit PARITY_ODD = (PARITY_TYPE == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [BITS_N-1:0] shift_reg, shift_reg_n;
    logic              parity_bit, parity_bit_n;
    logic              ready_n, uart_out_n, baud_trigger_n;
    logic              bit_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            ready        <= 1'b1;
            uart_out     <= 1'b1;
            baud_trigger <= 1'b0;
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_cnt_n;
            bit_cnt      <= bit_cnt_n;
            shift_reg    <= shift_reg_n;
            parity_bit   <= parity_bit_n;
            ready        <= ready_n;
            uart_out     <= uart_out_n;
            baud_trigger <= baud_trigger_n;
        end
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        bit_end      = (state != IDLE) && (baud_cnt == CNT_LAST);

        if (state != IDLE) begin
            baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (valid) begin
                    shift_reg_n  = data_tx;
                    parity_bit_n = PARITY_ODD ? ~(^data_tx) : ^data_tx;
                    bit_cnt_n    = '0;
                    baud_cnt_n   = '0;
                    state_n      = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_n = PARITY_EN ? PARITY : STOP;
                    end else begin
                        shift_reg_n = shift_reg >> 1;
                        bit_cnt_n   = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        ready_n        = (state_n == IDLE);
        baud_trigger_n = (state_n != IDLE) && (baud_cnt_n == CNT_LAST);
        case (state_n)
            START:   uart_out_n = 1'b0;
            DATA:    uart_out_n = shift_reg_n[0];
            PARITY:  uart_out_n = parity_bit_n;
            default: uart_out_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: three instances (no / even / odd parity) share one
// stimulus stream and are checked every cycle against a frame-position model.
module tb_uart_tx_core;

    localparam int C = 4;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data_tx = 8'h00;
    logic [2:0] uo, rdy, bt;

    int checks_total = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    uart_tx_core #(.CLKS_PER_BIT(C), .BITS_N(N), .PARITY_TYPE(0)) dut_none (
        .clk(clk), .rst(rst), .data_tx(data_tx), .valid(valid),
        .ready(rdy[0]), .uart_out(uo[0]), .baud_trigger(bt[0]));
    uart_tx_core #(.CLKS_PER_BIT(C), .BITS_N(N), .PARITY_TYPE(1)) dut_odd (
        .clk(clk), .rst(rst), .data_tx(data_tx), .valid(valid),
        .ready(rdy[1]), .uart_out(uo[1]), .baud_trigger(bt[1]));
    uart_tx_core #(.CLKS_PER_BIT(C), .BITS_N(N), .PARITY_TYPE(2)) dut_even (
        .clk(clk), .rst(rst), .data_tx(data_tx), .valid(valid),
        .ready(rdy[2]), .uart_out(uo[2]), .baud_trigger(bt[2]));

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Model: each instance is either idle (pos = -1) or pos cycles into a frame
    // whose bit list is built from the word at acceptance.
    int       ptype [3] = '{0, 1, 2};
    int       pos [3] = '{-1, -1, -1};
    int       flen [3] = '{10, 10, 10};
    logic     fbits [3][11];
    bit       started = 0;

    always @(posedge clk) begin
        started = 1;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                pos[k] = -1;
            end else if (pos[k] < 0) begin
                if (valid) begin
                    fbits[k][0] = 1'b0;
                    for (int j = 0; j < N; j++) fbits[k][1+j] = data_tx[j];
                    if (ptype[k] == 0) begin
                        fbits[k][N+1] = 1'b1;
                        flen[k] = N + 2;
                    end else begin
                        fbits[k][N+1] = (ptype[k] == 2) ? ^data_tx : ~(^data_tx);
                        fbits[k][N+2] = 1'b1;
                        flen[k] = N + 3;
                    end
                    pos[k] = 0;
                end
            end else begin
                pos[k]++;
                if (pos[k] == flen[k] * C) pos[k] = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                if (pos[k] < 0) begin
                    checkOutput($sformatf("cyc_line%0d", k), uo[k], 1);
                    checkOutput($sformatf("cyc_ready%0d", k), rdy[k], 1);
                    checkOutput($sformatf("cyc_baud%0d", k), bt[k], 0);
                end else begin
                    checkOutput($sformatf("cyc_line%0d", k), uo[k], fbits[k][pos[k] / C]);
                    checkOutput($sformatf("cyc_ready%0d", k), rdy[k], 0);
                    checkOutput($sformatf("cyc_baud%0d", k), bt[k], (pos[k] % C) == C - 1);
                end
            end
        end
    end

    logic line_rec [3][100];
    logic ready_rec [3][100];
    logic baud_rec [3][100];

    // Start a frame, then record n cycles beginning with the first cycle after acceptance.
    task automatic applyStimulus(input logic [7:0] first, input bit hold, input int n,
                                 input int pulse_at, input int drop_at,
                                 input logic [7:0] next_data, input int rst_at);
        @(negedge clk);
        valid = 1'b1;
        data_tx = first;
        @(negedge clk);
        if (!hold) valid = 1'b0;
        data_tx = next_data;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                line_rec[k][i] = uo[k];
                ready_rec[k][i] = rdy[k];
                baud_rec[k][i] = bt[k];
            end
            if (pulse_at >= 0 && i == pulse_at) begin
                valid = 1'b1;
                data_tx = 8'hFF;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) valid = 1'b0;
            if (i == drop_at) valid = 1'b0;
            if (rst_at >= 0 && i == rst_at) rst = 1'b0;
            if (rst_at >= 0 && i == rst_at + 1) begin
                checkOutput("rst_mid_line", uo[0], 1);
                checkOutput("rst_mid_ready", rdy[0], 1);
                checkOutput("rst_mid_ready_par", rdy[2], 1);
                rst = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    function automatic int decodeByte(input int k, input int base);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = line_rec[k][base + (j + 1) * C + 1];
        return int'(b);
    endfunction

    function automatic int countLow(input int k, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (!ready_rec[k][i]) c++;
        return c;
    endfunction

    initial begin
        logic [9:0] frame_vec;
        int pulses;
        int zeros;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_line", uo[0], 1);
        checkOutput("reset_ready", rdy[0], 1);
        checkOutput("reset_baud", bt[0], 0);
        rst = 1'b1;
        zeros = 0;
        repeat (8) begin
            @(negedge clk);
            if (!uo[0]) zeros++;
        end
        checkOutput("idle_line_zeros", zeros, 0);

        applyStimulus(8'h55, 0, 48, -1, -1, 8'h55, -1);
        for (int b = 0; b < 10; b++) frame_vec[b] = line_rec[0][b * C + 1];
        checkOutput("frame55_bits", int'(frame_vec), 10'h2AA);
        checkOutput("frame55_ready_low", countLow(0, 48), 40);
        pulses = 0;
        for (int i = 0; i < 48; i++) if (baud_rec[0][i]) pulses++;
        checkOutput("frame55_baud_pulses", pulses, 10);
        checkOutput("frame55_baud_first", baud_rec[0][3], 1);
        checkOutput("frame55_baud_early", baud_rec[0][2], 0);
        checkOutput("frame55_ready_back", ready_rec[0][40], 1);

        applyStimulus(8'h07, 0, 48, -1, -1, 8'h07, -1);
        checkOutput("par07_even", line_rec[2][9 * C + 1], 1);
        checkOutput("par07_odd", line_rec[1][9 * C + 1], 0);
        checkOutput("par07_ready_low", countLow(2, 48), 44);

        applyStimulus(8'h00, 0, 48, -1, -1, 8'h00, -1);
        checkOutput("par00_even", line_rec[2][9 * C + 1], 0);
        checkOutput("par00_odd", line_rec[1][9 * C + 1], 1);

        applyStimulus(8'hA3, 0, 48, 12, -1, 8'hA3, -1);
        checkOutput("busy_byte", decodeByte(0, 0), 8'hA3);
        checkOutput("busy_ready_low", countLow(0, 48), 40);

        applyStimulus(8'h7B, 1, 96, -1, 45, 8'h22, -1);
        checkOutput("b2b_gap_ready", ready_rec[0][40], 1);
        checkOutput("b2b_last_stop", ready_rec[0][39], 0);
        checkOutput("b2b_second_start", line_rec[0][41], 0);
        checkOutput("b2b_byte1", decodeByte(0, 0), 8'h7B);
        checkOutput("b2b_byte2", decodeByte(0, 41), 8'h22);
        checkOutput("b2b_byte2_par", decodeByte(2, 45), 8'h22);

        applyStimulus(8'h0F, 0, 24, -1, -1, 8'h0F, 17);
        applyStimulus(8'h3A, 0, 48, -1, -1, 8'h3A, -1);
        checkOutput("after_rst_byte", decodeByte(0, 0), 8'h3A);
        checkOutput("after_rst_ready_low", countLow(0, 48), 40);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
